mdu_ctrl: RTL and testbench

Sequencing controller for the multiply/divide unit (MDU) and the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU and, optionally, MADD/MADDU/MSUB/MSUBU from decode. It times each operation with a parametrised latency counter and produces the HI/LO write strobe. It also stalls decode for any HI/LO access while an operation is in flight. It sits between the ID-stage control decoder and the MDU datapath, and replaces fixed-latency start/visit handling with a parametrised, killable sequencer.

---
 rtl/mdu_ctrl_if.sv | 28 ++
 rtl/mdu_ctrl.sv | 96 +++++++++
 tb/tb_mdu_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Decode-side handshake bundle between the ID stage and the MDU sequencer.
// master = decode / pipeline control, slave = mdu_ctrl.
interface mdu_ctrl_if;
  logic       id_valid;
  logic       id_start;
  logic [2:0] id_op;
  logic       id_rhl_visit;
  logic       stall_in;
  logic       mdu_kill;

  logic       mdu_issue;
  logic [2:0] mdu_op;
  logic [1:0] acc_mode;
  logic       mdu_busy;
  logic       mdu_done;
  logic       mdu_stall;
  logic       mdu_ri;

  modport master (
    output id_valid, id_start, id_op, id_rhl_visit, stall_in, mdu_kill,
    input  mdu_issue, mdu_op, acc_mode, mdu_busy, mdu_done, mdu_stall, mdu_ri
  );

  modport slave (
    input  id_valid, id_start, id_op, id_rhl_visit, stall_in, mdu_kill,
    output mdu_issue, mdu_op, acc_mode, mdu_busy, mdu_done, mdu_stall, mdu_ri
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: issues MDU ops from decode, times them with a
// down-counter, raises the HI/LO write strobe and stalls HI/LO accesses
// while an op is in flight.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no op in flight; an MDU op from decode may issue
// BUSY  | op in flight; cnt counts down, done fires when cnt reaches 0
module mdu_ctrl #(
  parameter int MUL_LAT     = 4,
  parameter int DIV_LAT     = 33,
  parameter int CNT_W       = 6,
  parameter int ENABLE_MADD = 1
) (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MUL_LD   = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV_LAT - 1);
  localparam logic             MADD_OFF = (ENABLE_MADD == 0);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [1:0]       acc_q;

  logic             ri;
  logic             accept;
  logic [CNT_W-1:0] cnt_ld;
  logic [1:0]       acc_d;

  // Decode-side qualification: reserved accumulate ops and the issue condition.
  always_comb begin
    ri     = bus.id_valid & bus.id_start & bus.id_op[2] & MADD_OFF;
    accept = bus.id_valid & bus.id_start & ~bus.stall_in & ~bus.mdu_kill &
             ~ri & (state_q == IDLE);
    cnt_ld = (bus.id_op[2:1] == 2'b01) ? DIV_LD : MUL_LD;
    case (bus.id_op[2:1])
      2'b10:   acc_d = 2'b01;
      2'b11:   acc_d = 2'b10;
      default: acc_d = 2'b00;
    endcase
  end

  // Sequencer FSM; kill takes priority over the terminal-count done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      acc_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
            cnt_q   <= cnt_ld;
            op_q    <= bus.id_op;
            acc_q   <= acc_d;
          end
        end
        BUSY: begin
          if (bus.mdu_kill) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Issue and stall are gated by reset so nothing leaks out while it is held.
  // The stall covers the done cycle because HI/LO is only written at its end.
  always_comb begin
    bus.mdu_issue = accept & rst;
    bus.mdu_op    = op_q;
    bus.acc_mode  = acc_q;
    bus.mdu_busy  = (state_q == BUSY);
    bus.mdu_done  = (state_q == BUSY) & (cnt_q == '0) & ~bus.mdu_kill;
    bus.mdu_stall = bus.id_valid & bus.id_rhl_visit & (state_q == BUSY) & rst;
    bus.mdu_ri    = ri;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a per-cycle vector table for MULT/MSUB/MADDU
// traffic, plus hand sequences for DIV latency, kill, reset and MADD gating.
module tb_mdu_ctrl;

  logic clk;
  logic rst;

  mdu_ctrl_if bus ();
  mdu_ctrl_if bus_nm ();

  mdu_ctrl #(.MUL_LAT(4), .DIV_LAT(33), .CNT_W(6), .ENABLE_MADD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mdu_ctrl #(.MUL_LAT(4), .DIV_LAT(33), .CNT_W(6), .ENABLE_MADD(0)) dut_nm (
    .clk (clk),
    .rst (rst),
    .bus (bus_nm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v, s;
    logic [2:0] op;
    logic       rhl, stl, kil;
    logic       e_issue, e_busy, e_done, e_stall;
    logic [2:0] e_op;
    logic [1:0] e_acc;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[24];

  function automatic vec_t tv(logic v, logic s, logic [2:0] op, logic rhl, logic stl,
                              logic kil, logic iss, logic bsy, logic dn, logic stall,
                              logic [2:0] eop, logic [1:0] eacc);
    vec_t r;
    r.v = v; r.s = s; r.op = op; r.rhl = rhl; r.stl = stl; r.kil = kil;
    r.e_issue = iss; r.e_busy = bsy; r.e_done = dn; r.e_stall = stall;
    r.e_op = eop; r.e_acc = eacc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input logic s, input logic [2:0] op,
                     input logic rhl, input logic stl, input logic kil);
    bus.id_valid = v; bus.id_start = s; bus.id_op = op;
    bus.id_rhl_visit = rhl; bus.stall_in = stl; bus.mdu_kill = kil;
  endtask

  // Advance one cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic v, input logic s, input logic [2:0] op,
                     input logic rhl, input logic stl, input logic kil);
    @(posedge clk);
    #1;
    drv(v, s, op, rhl, stl, kil);
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    tbl[0]  = tv(0,0,3'd0,0,0,0, 0,0,0,0, 3'd0,2'd0);
    tbl[1]  = tv(1,1,3'd1,1,0,0, 1,0,0,0, 3'd0,2'd0);
    tbl[2]  = tv(1,0,3'd0,1,0,0, 0,1,0,1, 3'd1,2'd0);
    tbl[3]  = tv(1,0,3'd0,1,0,0, 0,1,0,1, 3'd1,2'd0);
    tbl[4]  = tv(1,0,3'd0,1,0,0, 0,1,0,1, 3'd1,2'd0);
    tbl[5]  = tv(1,0,3'd0,1,0,0, 0,1,1,1, 3'd1,2'd0);
    tbl[6]  = tv(1,0,3'd0,1,0,0, 0,0,0,0, 3'd1,2'd0);
    tbl[7]  = tv(1,1,3'd7,1,1,0, 0,0,0,0, 3'd1,2'd0);
    tbl[8]  = tv(1,1,3'd7,1,1,0, 0,0,0,0, 3'd1,2'd0);
    tbl[9]  = tv(1,1,3'd7,1,0,0, 1,0,0,0, 3'd1,2'd0);
    tbl[10] = tv(1,1,3'd1,1,0,0, 0,1,0,1, 3'd7,2'd2);
    tbl[11] = tv(1,1,3'd1,1,0,0, 0,1,0,1, 3'd7,2'd2);
    tbl[12] = tv(1,1,3'd1,1,0,0, 0,1,0,1, 3'd7,2'd2);
    tbl[13] = tv(1,1,3'd1,1,0,0, 0,1,1,1, 3'd7,2'd2);
    tbl[14] = tv(1,1,3'd1,1,0,0, 1,0,0,0, 3'd7,2'd2);
    tbl[15] = tv(0,0,3'd0,0,0,0, 0,1,0,0, 3'd1,2'd0);
    tbl[16] = tv(0,0,3'd0,0,0,0, 0,1,0,0, 3'd1,2'd0);
    tbl[17] = tv(0,0,3'd0,0,0,0, 0,1,0,0, 3'd1,2'd0);
    tbl[18] = tv(0,0,3'd0,0,0,0, 0,1,1,0, 3'd1,2'd0);
    tbl[19] = tv(0,0,3'd0,0,0,0, 0,0,0,0, 3'd1,2'd0);
    tbl[20] = tv(1,1,3'd0,0,0,1, 0,0,0,0, 3'd1,2'd0);
    tbl[21] = tv(1,1,3'd4,0,0,0, 1,0,0,0, 3'd1,2'd0);
    tbl[22] = tv(0,0,3'd0,0,0,1, 0,1,0,0, 3'd4,2'd1);
    tbl[23] = tv(0,0,3'd0,0,0,0, 0,0,0,0, 3'd4,2'd1);

    // Reset with an MDU op and HI/LO access presented: nothing may escape.
    rst = 1'b0;
    drv(1, 1, 3'd1, 1, 0, 0);
    bus_nm.id_valid = 0; bus_nm.id_start = 0; bus_nm.id_op = 0;
    bus_nm.id_rhl_visit = 0; bus_nm.stall_in = 0; bus_nm.mdu_kill = 0;
    repeat (3) @(negedge clk);
    chk("rst_issue", bus.mdu_issue, 0);
    chk("rst_stall", bus.mdu_stall, 0);
    chk("rst_busy",  bus.mdu_busy, 0);
    chk("rst_done",  bus.mdu_done, 0);
    chk("rst_op",    bus.mdu_op, 0);
    chk("rst_acc",   bus.acc_mode, 0);
    drv(0, 0, 3'd0, 0, 0, 0);
    rst = 1'b1;

    // Table: MULT latency, MSUB behind stall_in, back-to-back MULT, kill.
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].op, tbl[i].rhl, tbl[i].stl, tbl[i].kil);
      chk($sformatf("t%0d_issue", i), bus.mdu_issue, tbl[i].e_issue);
      chk($sformatf("t%0d_busy", i),  bus.mdu_busy,  tbl[i].e_busy);
      chk($sformatf("t%0d_done", i),  bus.mdu_done,  tbl[i].e_done);
      chk($sformatf("t%0d_stall", i), bus.mdu_stall, tbl[i].e_stall);
      chk($sformatf("t%0d_op", i),    bus.mdu_op,    tbl[i].e_op);
      chk($sformatf("t%0d_acc", i),   bus.acc_mode,  tbl[i].e_acc);
    end

    // DIVU with MFLO decoded from T+1: stall T+1..T+33, single done at T+33.
    cyc(1, 1, 3'd2, 1, 0, 0);
    chk("div_issue", bus.mdu_issue, 1);
    ndone = 0;
    for (int k = 1; k <= 33; k++) begin
      cyc(1, 0, 3'd0, 1, 0, 0);
      chk($sformatf("div_stall_%0d", k), bus.mdu_stall, 1);
      chk($sformatf("div_busy_%0d", k),  bus.mdu_busy, 1);
      chk($sformatf("div_done_%0d", k),  bus.mdu_done, (k == 33));
      if (bus.mdu_done) ndone++;
    end
    cyc(1, 0, 3'd0, 1, 0, 0);
    chk("div_stall_34", bus.mdu_stall, 0);
    chk("div_busy_34",  bus.mdu_busy, 0);
    chk("div_op",       bus.mdu_op, 3'd2);
    chk("div_ndone",    ndone, 1);

    // Kill in the done cycle of a MULT: no done, back to IDLE, issue works again.
    cyc(1, 1, 3'd1, 0, 0, 0);
    chk("kill_issue", bus.mdu_issue, 1);
    for (int k = 1; k <= 3; k++) cyc(0, 0, 3'd0, 0, 0, 0);
    cyc(0, 0, 3'd0, 0, 0, 1);
    chk("kill_done_t4", bus.mdu_done, 0);
    chk("kill_busy_t4", bus.mdu_busy, 1);
    cyc(1, 1, 3'd0, 0, 0, 0);
    chk("kill_busy_t5", bus.mdu_busy, 0);
    chk("kill_done_t5", bus.mdu_done, 0);
    chk("kill_reissue", bus.mdu_issue, 1);
    for (int k = 1; k <= 5; k++) cyc(0, 0, 3'd0, 0, 0, 0);
    chk("kill_drained", bus.mdu_busy, 0);

    // Reset asserted at T+10 of a DIV: busy/done drop at once, then MULTU issues.
    cyc(1, 1, 3'd3, 0, 0, 0);
    chk("rmid_issue", bus.mdu_issue, 1);
    for (int k = 1; k <= 9; k++) cyc(0, 0, 3'd0, 0, 0, 0);
    cyc(1, 0, 3'd0, 1, 0, 0);
    chk("rmid_busy_pre",  bus.mdu_busy, 1);
    chk("rmid_stall_pre", bus.mdu_stall, 1);
    rst = 1'b0;
    #1;
    chk("rmid_busy",  bus.mdu_busy, 0);
    chk("rmid_done",  bus.mdu_done, 0);
    chk("rmid_stall", bus.mdu_stall, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 1, 3'd0, 0, 0, 0);
    chk("rmid_new_issue", bus.mdu_issue, 1);
    cyc(0, 0, 3'd0, 0, 0, 0);
    chk("rmid_new_busy", bus.mdu_busy, 1);
    chk("rmid_new_op",   bus.mdu_op, 3'd0);
    chk("rmid_new_acc",  bus.acc_mode, 2'd0);
    for (int k = 1; k <= 4; k++) cyc(0, 0, 3'd0, 0, 0, 0);

    // ENABLE_MADD=0: MSUB is reserved and never issues; MULT still does.
    @(posedge clk);
    #1;
    bus_nm.id_valid = 1; bus_nm.id_start = 1; bus_nm.id_op = 3'd7;
    @(negedge clk);
    chk("nm_msub_ri",    bus_nm.mdu_ri, 1);
    chk("nm_msub_issue", bus_nm.mdu_issue, 0);
    chk("en_msub_ri",    bus.mdu_ri, 0);
    @(posedge clk);
    #1;
    bus_nm.id_valid = 0; bus_nm.id_start = 0; bus_nm.id_op = 3'd0;
    @(negedge clk);
    chk("nm_msub_busy", bus_nm.mdu_busy, 0);
    @(posedge clk);
    #1;
    bus_nm.id_valid = 1; bus_nm.id_start = 1; bus_nm.id_op = 3'd1;
    @(negedge clk);
    chk("nm_mult_ri",    bus_nm.mdu_ri, 0);
    chk("nm_mult_issue", bus_nm.mdu_issue, 1);
    @(posedge clk);
    #1;
    bus_nm.id_valid = 0; bus_nm.id_start = 0;
    @(negedge clk);
    chk("nm_mult_busy", bus_nm.mdu_busy, 1);
    chk("nm_mult_op",   bus_nm.mdu_op, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
